imem_responder: RTL and testbench

- Instruction-memory responder for the RV32I core. It is the other end of the fetch interface driven by the program counter.
- Accepts word-indexed fetch requests over a valid/ready handshake and returns 32-bit instructions in request order after a fixed read latency.
- Buffers responses so that back-pressure never loses data. Supports a flush on control-flow redirect.
- Has a simple program-load write port used by the testbench and boot logic.

---
 rtl/rv32i_pkg.sv | 11 +
 rtl/imem_responder_rsp_fifo.sv | 54 +++++
 rtl/imem_responder.sv | 110 +++++++++++
 tb/tb_imem_responder.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/rv32i_pkg.sv
// Types and constants shared by the RV32I instruction-fetch path.
// Zero latency. No flow control of its own.
package rv32i_pkg;
   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic            err;
   } fetch_rsp_t;
endpackage

// File: rtl/imem_responder_rsp_fifo.sv
// First-word-fall-through FIFO of fetch responses, with a sync clear for flush. A push that arrives with clr survives.
// Data shows at the head the cycle after it is written. The caller's credit scheme guarantees a push never meets a full FIFO.
module rsp_fifo
   import rv32i_pkg::*;
#(
   parameter int unsigned DEPTH = 2
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           clr,
   input  logic                           wr_vld,
   input  fetch_rsp_t                     wr_dat,
   output logic                           rd_vld,
   input  logic                           rd_rdy,
   output fetch_rsp_t                     rd_dat,
   output logic [$clog2(DEPTH+1)-1:0]     count
);
   localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = $clog2(DEPTH + 1);

   fetch_rsp_t      mem_q [DEPTH];
   logic [PW-1:0]   wr_ptr;
   logic [PW-1:0]   rd_ptr;
   logic [PW-1:0]   wr_idx;
   logic            rd_fire;

   function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   assign rd_vld  = (count != '0);
   assign rd_fire = rd_vld & rd_rdy & ~clr;
   // After a clear, the redirected entry lands in slot 0.
   assign wr_idx  = clr ? '0 : wr_ptr;
   assign rd_dat  = rd_vld ? mem_q[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (wr_vld) begin
         mem_q[wr_idx] <= wr_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_vld ? next_ptr(wr_idx) : wr_idx;
         rd_ptr <= clr ? '0 : (rd_fire ? next_ptr(rd_ptr) : rd_ptr);
         count  <= (clr ? '0 : count) + CW'(wr_vld) - CW'(rd_fire);
      end
   end
endmodule

// File: rtl/imem_responder.sv
// Instruction memory answering in-order fetches, with a program-load port and flush on redirect.
// Response valid LATENCY cycles after the accept cycle. Credits cap pipeline plus FIFO at LATENCY+1, so back-pressure never drops data.
module imem_responder #(
   parameter int unsigned DEPTH     = 1024,
   parameter int unsigned LATENCY   = 1,
   parameter logic [31:0] NOP_INSTR = rv32i_pkg::NOP_INSTR
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_req_valid,
   output logic        o_req_ready,
   input  logic [31:0] i_req_addr,
   output logic        o_rsp_valid,
   input  logic        i_rsp_ready,
   output logic [31:0] o_rsp_instr,
   output logic        o_rsp_err,
   input  logic        i_flush,
   input  logic        i_load_en,
   input  logic [31:0] i_load_addr,
   input  logic [31:0] i_load_data
);
   import rv32i_pkg::*;

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = $clog2(LATENCY + 2);

   logic [XLEN-1:0] mem [DEPTH];
   logic            accept;
   logic            oor;
   fetch_rsp_t      rd_rsp;
   logic            push_vld;
   fetch_rsp_t      push_dat;
   fetch_rsp_t      rsp_dat;
   logic [CW-1:0]   pipe_cnt;
   logic [CW-1:0]   fifo_cnt;
   logic            unused_load_bits;

   assign unused_load_bits = ^i_load_addr[31:AW];

   // Credit looks only at registered occupancy; a pop this cycle frees its slot next cycle.
   assign o_req_ready = ({1'b0, pipe_cnt} + {1'b0, fifo_cnt}) < (CW+1)'(LATENCY + 1);
   assign accept      = i_req_valid & o_req_ready;

   always_ff @(posedge i_clk) begin
      if (i_load_en) begin
         mem[i_load_addr[AW-1:0]] <= i_load_data;
      end
   end

   // Combinational read sees pre-write contents when a load hits the same word.
   assign oor          = (i_req_addr >= 32'(DEPTH));
   assign rd_rsp.err   = oor;
   assign rd_rsp.instr = oor ? NOP_INSTR : mem[i_req_addr[AW-1:0]];

   generate
      if (LATENCY == 1) begin : g_direct
         assign push_vld = accept;
         assign push_dat = rd_rsp;
         assign pipe_cnt = '0;
      end else begin : g_pipe
         logic       stg_vld [LATENCY-1];
         fetch_rsp_t stg_dat [LATENCY-1];

         // A request accepted with flush is the redirected fetch, so stage 0 still loads.
         always_ff @(posedge i_clk) begin
            if (i_reset) begin
               for (int k = 0; k < LATENCY - 1; k++) begin
                  stg_vld[k] <= 1'b0;
               end
            end else begin
               stg_vld[0] <= accept;
               for (int k = 1; k < LATENCY - 1; k++) begin
                  stg_vld[k] <= stg_vld[k-1] & ~i_flush;
               end
            end
            stg_dat[0] <= rd_rsp;
            for (int k = 1; k < LATENCY - 1; k++) begin
               stg_dat[k] <= stg_dat[k-1];
            end
         end

         assign push_vld = stg_vld[LATENCY-2] & ~i_flush;
         assign push_dat = stg_dat[LATENCY-2];

         always_comb begin
            pipe_cnt = '0;
            for (int k = 0; k < LATENCY - 1; k++) begin
               pipe_cnt = pipe_cnt + CW'(stg_vld[k]);
            end
         end
      end
   endgenerate

   rsp_fifo #(
      .DEPTH (LATENCY + 1)
   ) u_rsp_fifo (
      .clk    (i_clk),
      .rst    (i_reset),
      .clr    (i_flush),
      .wr_vld (push_vld),
      .wr_dat (push_dat),
      .rd_vld (o_rsp_valid),
      .rd_rdy (i_rsp_ready),
      .rd_dat (rsp_dat),
      .count  (fifo_cnt)
   );

   assign o_rsp_instr = rsp_dat.instr;
   assign o_rsp_err   = rsp_dat.err;
endmodule

// File: tb/tb_imem_responder.sv
// Directed bench: three responders (LATENCY 1, 2, 3) share stimulus; each scenario checks the instance it targets.
module tb_imem_responder;
   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic [31:0] req_addr;
   logic        rsp_ready;
   logic        flush;
   logic        load_en;
   logic [31:0] load_addr;
   logic [31:0] load_data;

   logic [2:0]  req_ready;
   logic [2:0]  rsp_valid;
   logic [2:0]  rsp_err;
   logic [31:0] rsp_instr [3];

   int total = 0;
   int bad   = 0;

   logic [31:0] prog [4];
   logic [31:0] oor_addr [3];
   logic [31:0] oor_instr [3];
   logic [31:0] fl_addr [3];

   localparam logic [31:0] MEM5  = 32'h0050_0293;
   localparam logic [31:0] MEM10 = 32'h0A0A_0A0A;
   localparam logic [31:0] MEM11 = 32'h0B0B_0B0B;
   localparam logic [31:0] MEM40 = 32'h2828_2828;

   always #5 clk = ~clk;

   genvar g;
   generate
      for (g = 0; g < 3; g++) begin : g_dut
         imem_responder #(
            .DEPTH     (1024),
            .LATENCY   (g + 1),
            .NOP_INSTR (32'h0000_0013)
         ) dut (
            .i_clk       (clk),
            .i_reset     (rst),
            .i_req_valid (req_valid),
            .o_req_ready (req_ready[g]),
            .i_req_addr  (req_addr),
            .o_rsp_valid (rsp_valid[g]),
            .i_rsp_ready (rsp_ready),
            .o_rsp_instr (rsp_instr[g]),
            .o_rsp_err   (rsp_err[g]),
            .i_flush     (flush),
            .i_load_en   (load_en),
            .i_load_addr (load_addr),
            .i_load_data (load_data)
         );
      end
   endgenerate

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [31:0] a, input logic [31:0] d);
      load_en   = 1'b1;
      load_addr = a;
      load_data = d;
      tick();
      load_en   = 1'b0;
   endtask

   initial begin
      prog[0] = 32'h0010_0093; prog[1] = 32'h0020_0113;
      prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_0013;
      oor_addr[0]  = 32'd1024;       oor_addr[1]  = 32'hFFFF_FFFF; oor_addr[2]  = 32'd5;
      oor_instr[0] = 32'h0000_0013;  oor_instr[1] = 32'h0000_0013; oor_instr[2] = MEM5;
      fl_addr[0] = 32'd10; fl_addr[1] = 32'd11; fl_addr[2] = 32'd40;

      rst = 1'b1; req_valid = 1'b0; req_addr = '0; rsp_ready = 1'b1;
      flush = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
      tick();
      tick();
      for (int d = 0; d < 3; d++) begin
         check($sformatf("reset_vld%0d", d),   32'(rsp_valid[d]), 32'd0);
         check($sformatf("reset_err%0d", d),   32'(rsp_err[d]),   32'd0);
         check($sformatf("reset_instr%0d", d), rsp_instr[d],      32'd0);
         check($sformatf("reset_rdy%0d", d),   32'(req_ready[d]), 32'd1);
      end
      rst = 1'b0;

      for (int i = 0; i < 4; i++) load(32'(i), prog[i]);
      load(32'd5, MEM5);
      load(32'd7, 32'hAAAA_AAAA);
      load(32'd10, MEM10);
      load(32'd11, MEM11);
      load(32'd40, MEM40);

      // Back-to-back fetches, LATENCY 1.
      for (int i = 0; i < 5; i++) begin
         req_valid = (i < 4);
         req_addr  = 32'(i);
         if (i < 4) check($sformatf("b2b_rdy%0d", i), 32'(req_ready[0]), 32'd1);
         check($sformatf("b2b_vld%0d", i), 32'(rsp_valid[0]), 32'(i > 0));
         if (i > 0) begin
            check($sformatf("b2b_instr%0d", i), rsp_instr[0], prog[i-1]);
            check($sformatf("b2b_err%0d", i),   32'(rsp_err[0]), 32'd0);
         end
         tick();
      end
      req_valid = 1'b0;
      check("b2b_end_vld", 32'(rsp_valid[0]), 32'd0);
      repeat (6) tick();

      // Back-pressure, LATENCY 2: three credits, head held while stalled.
      rsp_ready = 1'b0;
      for (int k = 0; k < 6; k++) begin
         req_valid = 1'b1;
         req_addr  = (k < 3) ? 32'(k) : 32'd3;
         check($sformatf("bp_rdy%0d", k), 32'(req_ready[1]), 32'(k < 3));
         check($sformatf("bp_vld%0d", k), 32'(rsp_valid[1]), 32'(k >= 2));
         if (k >= 2) check($sformatf("bp_hold%0d", k), rsp_instr[1], prog[0]);
         tick();
      end
      req_valid = 1'b0;
      rsp_ready = 1'b1;
      check("bp_credit_lag", 32'(req_ready[1]), 32'd0);
      for (int k = 0; k < 3; k++) begin
         check($sformatf("bp_drain_vld%0d", k),   32'(rsp_valid[1]), 32'd1);
         check($sformatf("bp_drain_instr%0d", k), rsp_instr[1], prog[k]);
         tick();
         if (k == 0) check("bp_credit_back", 32'(req_ready[1]), 32'd1);
      end
      check("bp_drain_end", 32'(rsp_valid[1]), 32'd0);
      repeat (8) tick();

      // Out-of-range fetches, LATENCY 1.
      for (int k = 0; k < 4; k++) begin
         req_valid = (k < 3);
         req_addr  = (k < 3) ? oor_addr[k] : 32'd0;
         if (k < 3) check($sformatf("oor_rdy%0d", k), 32'(req_ready[0]), 32'd1);
         if (k > 0) begin
            check($sformatf("oor_vld%0d", k),   32'(rsp_valid[0]), 32'd1);
            check($sformatf("oor_instr%0d", k), rsp_instr[0], oor_instr[k-1]);
            check($sformatf("oor_err%0d", k),   32'(rsp_err[0]), 32'(k < 3));
         end
         tick();
      end
      req_valid = 1'b0;
      repeat (6) tick();

      // Flush with a redirected fetch in the same cycle, LATENCY 3.
      for (int k = 0; k < 7; k++) begin
         req_valid = (k < 3);
         req_addr  = (k < 3) ? fl_addr[k] : 32'd0;
         flush     = (k == 2);
         if (k < 3) check($sformatf("fl_rdy%0d", k), 32'(req_ready[2]), 32'd1);
         check($sformatf("fl_vld%0d", k), 32'(rsp_valid[2]), 32'(k == 5));
         if (k == 5) check("fl_instr", rsp_instr[2], MEM40);
         tick();
      end
      req_valid = 1'b0;
      flush     = 1'b0;
      repeat (6) tick();

      // Load and fetch of the same word in one cycle; load address upper bits ignored.
      load_en = 1'b1; load_addr = 32'h0000_0407; load_data = 32'h5555_5555;
      req_valid = 1'b1; req_addr = 32'd7;
      tick();
      load_en = 1'b0;
      check("col_old_vld",   32'(rsp_valid[0]), 32'd1);
      check("col_old_instr", rsp_instr[0], 32'hAAAA_AAAA);
      tick();
      req_valid = 1'b0;
      check("col_new_instr", rsp_instr[0], 32'h5555_5555);
      repeat (6) tick();

      // Reset with three requests outstanding, LATENCY 3.
      rsp_ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         req_valid = 1'b1;
         req_addr  = 32'(k);
         tick();
      end
      req_valid = 1'b0;
      check("mid_pre_vld", 32'(rsp_valid[2]), 32'd1);
      rst = 1'b1;
      tick();
      for (int d = 0; d < 3; d++) begin
         check($sformatf("mid_vld%0d", d),   32'(rsp_valid[d]), 32'd0);
         check($sformatf("mid_err%0d", d),   32'(rsp_err[d]),   32'd0);
         check($sformatf("mid_instr%0d", d), rsp_instr[d],      32'd0);
         check($sformatf("mid_rdy%0d", d),   32'(req_ready[d]), 32'd1);
      end
      rst = 1'b0;
      rsp_ready = 1'b1;
      for (int k = 0; k < 5; k++) begin
         check($sformatf("mid_stale%0d", k), 32'(rsp_valid), 32'd0);
         tick();
      end
      req_valid = 1'b1;
      req_addr  = 32'd2;
      tick();
      req_valid = 1'b0;
      tick();
      tick();
      check("mid_mem_vld",   32'(rsp_valid[2]), 32'd1);
      check("mid_mem_instr", rsp_instr[2], prog[2]);
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
